regblock_seq: RTL and testbench

- Multi-cycle sequencer for the register-file / sign-extend / operand-mux / ALU datapath block.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes the fields.
- Drives the datapath's read/write addresses, operand-mux select, immediate and ALU op-select.
- Latches the ALU result and writes it back to the register file. Also arbitrates a host preload write port onto the same register-file write port.

---
 rtl/regblock_pkg.sv | 31 +++
 rtl/regblock_seq_decode.sv | 27 ++
 rtl/regblock_seq.sv | 132 +++++++++++++
 tb/tb_regblock_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regblock_pkg.sv
// regblock_pkg: shared types and instruction field positions for the regblock sequencer.
`default_nettype none
package regblock_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam int OPSEL_MSB  = 31;
  localparam int OPSEL_LSB  = 28;
  localparam int IMMSEL_BIT = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 21;
  localparam int RS_MSB     = 20;
  localparam int RS_LSB     = 15;
  localparam int RT_MSB     = 14;
  localparam int RT_LSB     = 9;
  localparam int IMM_MSB    = 14;

  typedef struct packed {
    logic [3:0]  opsel;
    logic        imm_sel;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [14:0] low15;
  } instr_t;

endpackage
`default_nettype wire

// File: rtl/regblock_seq_decode.sv
// regblock_seq_decode: combinational field extraction from a latched instruction word.
`default_nettype none
module regblock_seq_decode
  import regblock_pkg::*;
(
  input  instr_t      iw,
  output logic [5:0]  rs,
  output logic [5:0]  rt,
  output logic [5:0]  rd,
  output logic        mux_sel,
  output logic [14:0] imm_in,
  output logic [3:0]  alu_opsel
);

  logic [31:0] w;
  assign w = iw;

  assign alu_opsel = w[OPSEL_MSB:OPSEL_LSB];
  assign mux_sel   = w[IMMSEL_BIT];
  assign rd        = w[RD_MSB:RD_LSB];
  assign rs        = w[RS_MSB:RS_LSB];
  assign imm_in    = w[IMM_MSB:0];
  // The rt bits overlap the immediate, so they are suppressed in immediate mode.
  assign rt        = w[IMMSEL_BIT] ? 6'd0 : w[RT_MSB:RT_LSB];

endmodule
`default_nettype wire

// File: rtl/regblock_seq.sv
// regblock_seq: IDLE/EXEC/WB sequencer driving the regfile/ALU datapath, with host preload arbitration.
`default_nettype none
module regblock_seq
  import regblock_pkg::*;
#(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int IMM_IN = 15,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [RWIDTH-1:0] host_wa,
  input  logic [DWIDTH-1:0] host_wd,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DWIDTH-1:0] alu_result,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              mux_sel,
  output logic [IMM_IN-1:0] imm_in,
  output logic [3:0]        alu_opsel,
  output logic [DWIDTH-1:0] result,
  output logic              done,
  output logic [CNTW-1:0]   retired
);

  state_t            state;
  state_t            state_nxt;
  instr_t            instr_q;
  logic [DWIDTH-1:0] result_q;
  logic [CNTW-1:0]   retired_q;

  logic [5:0]  d_rs;
  logic [5:0]  d_rt;
  logic [5:0]  d_rd;
  logic        d_mux;
  logic [14:0] d_imm;
  logic [3:0]  d_op;

  logic in_idle;
  logic accept;

  // Ready/accept are qualified with rst_n so every output reads 0 while reset is held.
  assign in_idle = rst_n && (state == S_IDLE);
  assign accept  = in_idle && !host_valid && instr_valid;

  regblock_seq_decode u_decode (
    .iw        (instr_q),
    .rs        (d_rs),
    .rt        (d_rt),
    .rd        (d_rd),
    .mux_sel   (d_mux),
    .imm_in    (d_imm),
    .alu_opsel (d_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr_t'(instr);
      end
      if (state == S_EXEC) begin
        result_q <= alu_result;
      end
      if (state == S_WB) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  always_comb begin
    instr_ready = in_idle && !host_valid;
    host_ready  = in_idle;
    we          = 1'b0;
    done        = 1'b0;
    rd          = RWIDTH'(d_rd);
    wd          = result_q;
    case (state)
      S_IDLE: begin
        if (in_idle && host_valid) begin
          we = 1'b1;
          rd = host_wa;
          wd = host_wd;
        end
      end
      S_WB: begin
        we   = (d_rd != 6'd0);
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs        = RWIDTH'(d_rs);
  assign rt        = RWIDTH'(d_rt);
  assign mux_sel   = d_mux;
  assign imm_in    = IMM_IN'(d_imm);
  assign alu_opsel = d_op;
  assign result    = result_q;
  assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_regblock_seq.sv
// tb_regblock_seq: directed vectors against a bench-side register file and ALU model.
`timescale 1ns/1ps
`default_nettype none
module tb_regblock_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [5:0]  host_wa = '0;
  logic [31:0] host_wd = '0;
  logic        host_valid = 1'b0;
  logic [31:0] alu_result;

  logic        instr_ready, host_ready, we, mux_sel, done;
  logic [5:0]  rs, rt, rd;
  logic [31:0] wd, result;
  logic [14:0] imm_in;
  logic [3:0]  alu_opsel;
  logic [15:0] retired;

  logic        x_instr_ready, x_host_ready, x_we, x_mux_sel, x_done;
  logic [5:0]  x_rs, x_rt, x_rd;
  logic [31:0] x_wd, x_result;
  logic [14:0] x_imm_in;
  logic [3:0]  x_alu_opsel;
  logic [3:0]  x_retired;

  always #5 clk = ~clk;

  regblock_seq u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .host_wa(host_wa), .host_wd(host_wd),
    .host_valid(host_valid), .host_ready(host_ready), .alu_result(alu_result),
    .rs(rs), .rt(rt), .rd(rd), .wd(wd), .we(we), .mux_sel(mux_sel),
    .imm_in(imm_in), .alu_opsel(alu_opsel), .result(result), .done(done),
    .retired(retired)
  );

  regblock_seq #(.CNTW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(x_instr_ready), .host_wa(host_wa), .host_wd(host_wd),
    .host_valid(host_valid), .host_ready(x_host_ready), .alu_result(alu_result),
    .rs(x_rs), .rt(x_rt), .rd(x_rd), .wd(x_wd), .we(x_we), .mux_sel(x_mux_sel),
    .imm_in(x_imm_in), .alu_opsel(x_alu_opsel), .result(x_result), .done(x_done),
    .retired(x_retired)
  );

  // Datapath model: register file, sign extender, operand mux, small ALU.
  logic [31:0] rf [0:63] = '{default: 32'd0};
  logic [31:0] op_a, op_b;

  always @(posedge clk) if (we) rf[rd] <= wd;

  always_comb begin
    op_a = rf[rs];
    op_b = mux_sel ? {{17{imm_in[14]}}, imm_in} : rf[rt];
    case (alu_opsel)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      default: alu_result = op_a ^ op_b;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;
  int exp_ret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic sel,
                                     input logic [5:0] rd_, input logic [5:0] rs_,
                                     input logic [14:0] lo);
    return {op, sel, rd_, rs_, lo};
  endfunction

  // Called just after a rising edge with the sequencer idle and no host request.
  task automatic issue(input logic [31:0] word, input logic [5:0] e_rd,
                       input logic [31:0] e_wd, input logic e_we, input logic [5:0] e_rt);
    instr = word;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_we", we, 0);
    chk("exec_done", done, 0);
    chk("exec_rt", rt, e_rt);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_we", we, e_we);
    chk("wb_rd", rd, e_rd);
    chk("wb_wd", wd, e_wd);
    chk("wb_result", result, e_wd);
    exp_ret++;
    @(posedge clk); #1;
    chk("retired", retired, exp_ret);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [31:0] d);
    host_valid = 1'b1;
    host_wa = a;
    host_wd = d;
    @(negedge clk);
    chk("host_ready", host_ready, 1);
    chk("host_we", we, 1);
    chk("host_rd", rd, a);
    chk("host_wd", wd, d);
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [5:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_we;
    logic [5:0]  e_rt;
  } vec_t;

  vec_t tv [6];

  initial begin
    int acc_cyc [4];
    int n_acc;
    int n_done;

    tv[0] = '{mk(4'd0, 1'b0, 6'd3, 6'd1, {6'd2, 9'd0}), 6'd3, 32'd12,   1'b1, 6'd2};
    tv[1] = '{mk(4'd0, 1'b1, 6'd4, 6'd1, 15'h7FFF),     6'd4, 32'd4,    1'b1, 6'd0};
    tv[2] = '{mk(4'd1, 1'b0, 6'd6, 6'd2, {6'd1, 9'd0}), 6'd6, 32'd2,    1'b1, 6'd1};
    tv[3] = '{mk(4'd0, 1'b0, 6'd0, 6'd1, {6'd2, 9'd0}), 6'd0, 32'd12,   1'b0, 6'd2};
    tv[4] = '{mk(4'd2, 1'b1, 6'd7, 6'd3, 15'h00F0),     6'd7, 32'hFC,   1'b1, 6'd0};
    tv[5] = '{mk(4'd0, 1'b0, 6'd8, 6'd7, {6'd4, 9'd0}), 6'd8, 32'h100,  1'b1, 6'd4};

    // Outputs stay 0 while reset is held, even with a host request pending.
    host_valid = 1'b1;
    #2;
    chk("rst_we", we, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_retired", retired, 0);
    chk("rst_result", result, 0);
    host_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    host_write(6'd1, 32'd5);
    host_write(6'd2, 32'd7);

    for (int i = 0; i < 6; i++) begin
      issue(tv[i].word, tv[i].e_rd, tv[i].e_wd, tv[i].e_we, tv[i].e_rt);
    end
    chk("r0_untouched", rf[0], 0);

    // Host and instruction offered together: host wins, instruction accepted next cycle.
    host_valid = 1'b1;
    host_wa = 6'd9;
    host_wd = 32'h55;
    instr = mk(4'd0, 1'b0, 6'd10, 6'd9, {6'd0, 9'd0});
    instr_valid = 1'b1;
    @(negedge clk);
    chk("arb_instr_ready", instr_ready, 0);
    chk("arb_we", we, 1);
    chk("arb_rd", rd, 9);
    chk("arb_wd", wd, 32'h55);
    @(posedge clk); #1;
    host_valid = 1'b0;
    issue(mk(4'd0, 1'b0, 6'd10, 6'd9, {6'd0, 9'd0}), 6'd10, 32'h55, 1'b1, 6'd0);

    // Back-to-back dependent increments of r5 with valid held high.
    instr = mk(4'd0, 1'b1, 6'd5, 6'd5, 15'd1);
    instr_valid = 1'b1;
    n_acc = 0;
    n_done = 0;
    for (int cyc = 0; cyc < 40 && n_done < 4; cyc++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (done) n_done++;
      @(posedge clk); #1;
      if (n_acc == 4) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    exp_ret += 4;
    chk("b2b_accepts", n_acc, 4);
    chk("b2b_dones", n_done, 4);
    if (n_acc == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    chk("b2b_r5", rf[5], 4);
    chk("b2b_retired", retired, exp_ret);

    // Asynchronous reset during EXEC aborts the instruction.
    instr = mk(4'd0, 1'b0, 6'd11, 6'd1, {6'd2, 9'd0});
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_done", done, 0);
    chk("arst_retired", retired, 0);
    chk("arst_instr_ready", instr_ready, 0);
    chk("arst_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_r11", rf[11], 0);
    chk("arst_idle_ready", instr_ready, 1);

    // Seventeen retirements: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      issue(mk(4'd0, 1'b0, 6'd0, 6'd0, 15'd0), 6'd0, 32'd0, 1'b0, 6'd0);
    end
    chk("wrap_retired4", x_retired, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
